regfile_wr_arb: RTL and testbench

Write-port controller for the 32×32 register file. Clears architectural registers 1..31 to zero after reset. It then arbitrates the single register-file write port between the pipeline writeback stage and the multicycle unit (mult/div result path). It uses valid/ready handshakes and a starvation guard. It sits between those two producers and the register file's `we`/`waddr`/`wdata` inputs.

---
 rtl/regfile_wr_arb_pkg.sv | 15 +
 rtl/regfile_wr_arb_if.sv | 33 +++
 rtl/regfile_wr_arb.sv | 108 ++++++++++
 tb/tb_regfile_wr_arb.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_wr_arb_pkg.sv
// Shared definitions for the register-file write-port controller and its consumers.
package regfile_wr_arb_pkg;

   localparam int unsigned AW = 5;
   localparam int unsigned DW = 32;

   localparam logic [AW-1:0] REG_ZERO = 5'd0;
   localparam logic [AW-1:0] REG_LAST = 5'd31;

   typedef enum logic [0:0] {
      ST_INIT,
      ST_RUN
   } state_e;

endpackage

// File: rtl/regfile_wr_arb_if.sv
// Write-request and register-file write bundle between the producers, the arbiter and the regfile.
interface regfile_wr_arb_if;
   import regfile_wr_arb_pkg::*;

   logic          init_done;

   logic          wb_valid;
   logic [AW-1:0] wb_addr;
   logic [DW-1:0] wb_data;
   logic          wb_ready;

   logic          mc_valid;
   logic [AW-1:0] mc_addr;
   logic [DW-1:0] mc_data;
   logic          mc_ready;

   logic          rf_we;
   logic [AW-1:0] rf_waddr;
   logic [DW-1:0] rf_wdata;

   // Producer/consumer side: drives requests, observes readies and the write port.
   modport master (
      output wb_valid, wb_addr, wb_data, mc_valid, mc_addr, mc_data,
      input  wb_ready, mc_ready, init_done, rf_we, rf_waddr, rf_wdata
   );

   // Arbiter side.
   modport slave (
      input  wb_valid, wb_addr, wb_data, mc_valid, mc_addr, mc_data,
      output wb_ready, mc_ready, init_done, rf_we, rf_waddr, rf_wdata
   );

endinterface

// File: rtl/regfile_wr_arb.sv
// Register-file write-port controller: clears x1..x31 after reset, then arbitrates the single
// write port between writeback (priority) and the multicycle unit, with a starvation guard.
module regfile_wr_arb
   import regfile_wr_arb_pkg::*;
#(
   parameter int unsigned STARVE_MAX = 4
) (
   input logic             clk,
   input logic             rst_,
   regfile_wr_arb_if.slave bus
);

   localparam int unsigned SW = $clog2(STARVE_MAX + 1);
   localparam logic [SW-1:0] STARVE_SAT = SW'(STARVE_MAX);

   state_e        state_q, state_d;
   logic [AW-1:0] sweep_q, sweep_d;
   logic [SW-1:0] starve_q, starve_d;
   logic          rf_we_q, rf_we_d;
   logic [AW-1:0] rf_waddr_q, rf_waddr_d;
   logic [DW-1:0] rf_wdata_q, rf_wdata_d;

   logic run, starved;
   logic wb_zero, wb_live, mc_zero, mc_live;
   logic wb_win, mc_win;

   // Grant decode: address-0 requests are absorbed without touching the port.
   always_comb begin
      run     = (state_q == ST_RUN);
      starved = (starve_q == STARVE_SAT);
      wb_zero = bus.wb_valid && (bus.wb_addr == REG_ZERO);
      wb_live = bus.wb_valid && (bus.wb_addr != REG_ZERO);
      mc_zero = bus.mc_valid && (bus.mc_addr == REG_ZERO);
      mc_live = bus.mc_valid && (bus.mc_addr != REG_ZERO);
      wb_win  = run && wb_live && !(starved && mc_live);
      mc_win  = run && mc_live && !wb_win;
   end

   // Readies depend only on valids, addresses, state and starvation count.
   always_comb begin
      bus.wb_ready  = run && (wb_zero || wb_win);
      bus.mc_ready  = run && (mc_zero || mc_win);
      bus.init_done = run;
      bus.rf_we     = rf_we_q;
      bus.rf_waddr  = rf_waddr_q;
      bus.rf_wdata  = rf_wdata_q;
   end

   // Next state: clear sweep in INIT, winner's write and starvation tracking in RUN.
   always_comb begin
      state_d    = state_q;
      sweep_d    = sweep_q;
      starve_d   = starve_q;
      rf_we_d    = 1'b0;
      rf_waddr_d = rf_waddr_q;
      rf_wdata_d = rf_wdata_q;
      unique case (state_q)
         ST_INIT: begin
            // sweep_q wraps to REG_ZERO once x31 is issued, marking the sweep complete.
            if (sweep_q == REG_ZERO) begin
               state_d = ST_RUN;
            end else begin
               rf_we_d    = 1'b1;
               rf_waddr_d = sweep_q;
               rf_wdata_d = '0;
               sweep_d    = (sweep_q == REG_LAST) ? REG_ZERO : sweep_q + 1'b1;
            end
         end
         ST_RUN: begin
            if (wb_win) begin
               rf_we_d    = 1'b1;
               rf_waddr_d = bus.wb_addr;
               rf_wdata_d = bus.wb_data;
            end else if (mc_win) begin
               rf_we_d    = 1'b1;
               rf_waddr_d = bus.mc_addr;
               rf_wdata_d = bus.mc_data;
            end
            if (mc_win) begin
               starve_d = '0;
            end else if (mc_live && (starve_q != STARVE_SAT)) begin
               starve_d = starve_q + 1'b1;
            end
         end
         default: state_d = ST_INIT;
      endcase
   end

   // State and registered write port.
   always_ff @(posedge clk or negedge rst_) begin
      if (!rst_) begin
         state_q    <= ST_INIT;
         sweep_q    <= AW'(1);
         starve_q   <= '0;
         rf_we_q    <= 1'b0;
         rf_waddr_q <= '0;
         rf_wdata_q <= '0;
      end else begin
         state_q    <= state_d;
         sweep_q    <= sweep_d;
         starve_q   <= starve_d;
         rf_we_q    <= rf_we_d;
         rf_waddr_q <= rf_waddr_d;
         rf_wdata_q <= rf_wdata_d;
      end
   end

endmodule

// File: tb/tb_regfile_wr_arb.sv
// Self-checking bench for regfile_wr_arb: expected writes are queued when a grant is predicted
// and popped when the registered write port should show them.
module tb_regfile_wr_arb;
   import regfile_wr_arb_pkg::*;

   typedef struct packed {
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
   } wr_t;

   logic clk;
   logic rst_;
   int   n_total;
   int   n_pass;
   wr_t  exp_q[$];

   regfile_wr_arb_if bus ();

   regfile_wr_arb #(
      .STARVE_MAX(4)
   ) dut (
      .clk (clk),
      .rst_(rst_),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic idle_inputs();
      bus.wb_valid = 1'b0;
      bus.wb_addr  = '0;
      bus.wb_data  = '0;
      bus.mc_valid = 1'b0;
      bus.mc_addr  = '0;
      bus.mc_data  = '0;
   endtask

   task automatic test_reset();
      rst_ = 1'b0;
      idle_inputs();
      bus.wb_valid = 1'b1;
      bus.wb_addr  = 5'd4;
      bus.mc_valid = 1'b1;
      bus.mc_addr  = 5'd6;
      repeat (2) @(posedge clk);
      #1;
      n_total++;
      if ({bus.rf_we, bus.rf_waddr, bus.rf_wdata} !== {1'b0, 5'd0, 32'd0})
         $display("FAIL reset_rf: got we=%b addr=%0d data=%h want 0/0/0",
                  bus.rf_we, bus.rf_waddr, bus.rf_wdata);
      else n_pass++;
      n_total++;
      if ({bus.init_done, bus.wb_ready, bus.mc_ready} !== 3'b000)
         $display("FAIL reset_ctl: got done/wbr/mcr=%b want 000",
                  {bus.init_done, bus.wb_ready, bus.mc_ready});
      else n_pass++;
      rst_ = 1'b1;
      for (int k = 1; k <= 31; k++) begin
         @(posedge clk);
         #1;
         n_total++;
         if ({bus.rf_we, bus.rf_waddr, bus.rf_wdata} !== {1'b1, 5'(k), 32'd0})
            $display("FAIL sweep_write[%0d]: got we=%b addr=%0d data=%h want 1/%0d/0",
                     k, bus.rf_we, bus.rf_waddr, bus.rf_wdata, k);
         else n_pass++;
         n_total++;
         if ({bus.init_done, bus.wb_ready, bus.mc_ready} !== 3'b000)
            $display("FAIL sweep_ctl[%0d]: got done/wbr/mcr=%b want 000",
                     k, {bus.init_done, bus.wb_ready, bus.mc_ready});
         else n_pass++;
      end
      idle_inputs();
      @(posedge clk);
      #1;
      n_total++;
      if ({bus.init_done, bus.rf_we} !== 2'b10)
         $display("FAIL sweep_done: got done/we=%b want 10", {bus.init_done, bus.rf_we});
      else n_pass++;
   endtask

   task automatic test_single_wb();
      wr_t e;
      bus.wb_valid = 1'b1;
      bus.wb_addr  = 5'd5;
      bus.wb_data  = 32'hDEAD_BEEF;
      #1;
      n_total++;
      if ({bus.wb_ready, bus.mc_ready} !== 2'b10)
         $display("FAIL single_wb_ready: got wbr/mcr=%b want 10", {bus.wb_ready, bus.mc_ready});
      else n_pass++;
      exp_q.push_back({5'd5, 32'hDEAD_BEEF});
      @(posedge clk);
      #1;
      idle_inputs();
      e = exp_q.pop_front();
      n_total++;
      if ({bus.rf_we, bus.rf_waddr, bus.rf_wdata} !== {1'b1, e.addr, e.data})
         $display("FAIL single_wb_write: got we=%b addr=%0d data=%h want 1/%0d/%h",
                  bus.rf_we, bus.rf_waddr, bus.rf_wdata, e.addr, e.data);
      else n_pass++;
      @(posedge clk);
      #1;
      n_total++;
      if ({bus.rf_we, bus.rf_waddr, bus.rf_wdata} !== {1'b0, 5'd5, 32'hDEAD_BEEF})
         $display("FAIL single_wb_hold: got we=%b addr=%0d data=%h want 0/5/deadbeef",
                  bus.rf_we, bus.rf_waddr, bus.rf_wdata);
      else n_pass++;
   endtask

   task automatic test_starvation();
      wr_t e;
      int  wb_n;
      int  mc_n;
      logic mc_exp;
      wb_n = 0;
      mc_n = 0;
      for (int i = 0; i < 10; i++) begin
         bus.wb_valid = 1'b1;
         bus.wb_addr  = 5'(10 + wb_n);
         bus.wb_data  = 32'h0000_1000 + 32'(wb_n);
         bus.mc_valid = 1'b1;
         bus.mc_addr  = 5'd20;
         bus.mc_data  = 32'hC0DE_0000 + 32'(mc_n);
         #1;
         // wb wins four in a row, then the fifth cycle goes to mc
         mc_exp = (i == 4) || (i == 9);
         n_total++;
         if ({bus.wb_ready, bus.mc_ready} !== {!mc_exp, mc_exp})
            $display("FAIL starve_ready[%0d]: got wbr/mcr=%b want %b",
                     i, {bus.wb_ready, bus.mc_ready}, {!mc_exp, mc_exp});
         else n_pass++;
         if (mc_exp) exp_q.push_back({5'd20, 32'hC0DE_0000 + 32'(mc_n)});
         else        exp_q.push_back({5'(10 + wb_n), 32'h0000_1000 + 32'(wb_n)});
         @(posedge clk);
         #1;
         e = exp_q.pop_front();
         n_total++;
         if ({bus.rf_we, bus.rf_waddr, bus.rf_wdata} !== {1'b1, e.addr, e.data})
            $display("FAIL starve_write[%0d]: got we=%b addr=%0d data=%h want 1/%0d/%h",
                     i, bus.rf_we, bus.rf_waddr, bus.rf_wdata, e.addr, e.data);
         else n_pass++;
         if (mc_exp) mc_n++;
         else        wb_n++;
      end
      idle_inputs();
   endtask

   task automatic test_addr_zero();
      wr_t e;
      // wb to x0 alongside mc to x7: both accepted, only x7 written
      bus.wb_valid = 1'b1;
      bus.wb_addr  = 5'd0;
      bus.wb_data  = 32'h0000_BAD0;
      bus.mc_valid = 1'b1;
      bus.mc_addr  = 5'd7;
      bus.mc_data  = 32'h7777_0007;
      #1;
      n_total++;
      if ({bus.wb_ready, bus.mc_ready} !== 2'b11)
         $display("FAIL zero_wb_ready: got wbr/mcr=%b want 11", {bus.wb_ready, bus.mc_ready});
      else n_pass++;
      exp_q.push_back({5'd7, 32'h7777_0007});
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      n_total++;
      if ({bus.rf_we, bus.rf_waddr, bus.rf_wdata} !== {1'b1, e.addr, e.data})
         $display("FAIL zero_wb_write: got we=%b addr=%0d data=%h want 1/%0d/%h",
                  bus.rf_we, bus.rf_waddr, bus.rf_wdata, e.addr, e.data);
      else n_pass++;
      // mc to x0 alongside wb to x3
      bus.wb_addr = 5'd3;
      bus.wb_data = 32'h3333_0003;
      bus.mc_addr = 5'd0;
      bus.mc_data = 32'h0000_BAD1;
      #1;
      n_total++;
      if ({bus.wb_ready, bus.mc_ready} !== 2'b11)
         $display("FAIL zero_mc_ready: got wbr/mcr=%b want 11", {bus.wb_ready, bus.mc_ready});
      else n_pass++;
      exp_q.push_back({5'd3, 32'h3333_0003});
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      n_total++;
      if ({bus.rf_we, bus.rf_waddr, bus.rf_wdata} !== {1'b1, e.addr, e.data})
         $display("FAIL zero_mc_write: got we=%b addr=%0d data=%h want 1/%0d/%h",
                  bus.rf_we, bus.rf_waddr, bus.rf_wdata, e.addr, e.data);
      else n_pass++;
      // both to x0: both accepted, no write
      bus.wb_addr = 5'd0;
      #1;
      n_total++;
      if ({bus.wb_ready, bus.mc_ready} !== 2'b11)
         $display("FAIL zero_both_ready: got wbr/mcr=%b want 11", {bus.wb_ready, bus.mc_ready});
      else n_pass++;
      @(posedge clk);
      #1;
      idle_inputs();
      n_total++;
      if (bus.rf_we !== 1'b0 || exp_q.size() != 0)
         $display("FAIL zero_both_nowrite: got we=%b addr=%0d want we=0",
                  bus.rf_we, bus.rf_waddr);
      else n_pass++;
   endtask

   task automatic test_same_addr();
      wr_t e;
      bus.wb_valid = 1'b1;
      bus.wb_addr  = 5'd9;
      bus.wb_data  = 32'hAAAA_0009;
      bus.mc_valid = 1'b1;
      bus.mc_addr  = 5'd9;
      bus.mc_data  = 32'hBBBB_0009;
      #1;
      n_total++;
      if ({bus.wb_ready, bus.mc_ready} !== 2'b10)
         $display("FAIL same_first_ready: got wbr/mcr=%b want 10", {bus.wb_ready, bus.mc_ready});
      else n_pass++;
      exp_q.push_back({5'd9, 32'hAAAA_0009});
      @(posedge clk);
      #1;
      bus.wb_valid = 1'b0;
      e = exp_q.pop_front();
      n_total++;
      if ({bus.rf_we, bus.rf_waddr, bus.rf_wdata} !== {1'b1, e.addr, e.data})
         $display("FAIL same_first_write: got we=%b addr=%0d data=%h want 1/%0d/%h",
                  bus.rf_we, bus.rf_waddr, bus.rf_wdata, e.addr, e.data);
      else n_pass++;
      #1;
      n_total++;
      if ({bus.wb_ready, bus.mc_ready} !== 2'b01)
         $display("FAIL same_second_ready: got wbr/mcr=%b want 01", {bus.wb_ready, bus.mc_ready});
      else n_pass++;
      exp_q.push_back({5'd9, 32'hBBBB_0009});
      @(posedge clk);
      #1;
      idle_inputs();
      e = exp_q.pop_front();
      n_total++;
      if ({bus.rf_we, bus.rf_waddr, bus.rf_wdata} !== {1'b1, e.addr, e.data})
         $display("FAIL same_second_write: got we=%b addr=%0d data=%h want 1/%0d/%h",
                  bus.rf_we, bus.rf_waddr, bus.rf_wdata, e.addr, e.data);
      else n_pass++;
      @(posedge clk);
      #1;
      n_total++;
      if (bus.rf_we !== 1'b0)
         $display("FAIL same_idle: got we=%b want 0", bus.rf_we);
      else n_pass++;
   endtask

   task automatic test_reset_mid_sweep();
      rst_ = 1'b0;
      @(posedge clk);
      #1;
      rst_ = 1'b1;
      for (int k = 1; k <= 10; k++) begin
         @(posedge clk);
         #1;
         n_total++;
         if ({bus.rf_we, bus.rf_waddr} !== {1'b1, 5'(k)})
            $display("FAIL midrst_pre[%0d]: got we=%b addr=%0d want 1/%0d",
                     k, bus.rf_we, bus.rf_waddr, k);
         else n_pass++;
      end
      // pending request across the reset must never be accepted or written
      bus.wb_valid = 1'b1;
      bus.wb_addr  = 5'd12;
      bus.wb_data  = 32'h1212_1212;
      #3;
      rst_ = 1'b0;
      #1;
      n_total++;
      if ({bus.rf_we, bus.rf_waddr, bus.rf_wdata, bus.init_done, bus.wb_ready, bus.mc_ready}
          !== {1'b0, 5'd0, 32'd0, 3'b000})
         $display("FAIL midrst_async: got we=%b addr=%0d data=%h done/wbr/mcr=%b want all 0",
                  bus.rf_we, bus.rf_waddr, bus.rf_wdata,
                  {bus.init_done, bus.wb_ready, bus.mc_ready});
      else n_pass++;
      repeat (2) @(posedge clk);
      #1;
      rst_ = 1'b1;
      for (int k = 1; k <= 31; k++) begin
         @(posedge clk);
         #1;
         n_total++;
         if ({bus.rf_we, bus.rf_waddr, bus.rf_wdata, bus.wb_ready} !== {1'b1, 5'(k), 32'd0, 1'b0})
            $display("FAIL midrst_sweep[%0d]: got we=%b addr=%0d data=%h wbr=%b want 1/%0d/0/0",
                     k, bus.rf_we, bus.rf_waddr, bus.rf_wdata, bus.wb_ready, k);
         else n_pass++;
      end
      idle_inputs();
      @(posedge clk);
      #1;
      n_total++;
      if ({bus.init_done, bus.rf_we} !== 2'b10)
         $display("FAIL midrst_done: got done/we=%b want 10", {bus.init_done, bus.rf_we});
      else n_pass++;
   endtask

   initial begin
      n_total = 0;
      n_pass  = 0;
      test_reset();
      test_single_wb();
      test_starvation();
      test_addr_zero();
      test_same_addr();
      test_reset_mid_sweep();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
